// File: rtl/adc_frame_capture.sv
// adc_frame_capture: sync-triggered delayed burst capture of ADC samples, drained over valid/ready.
// Define ADC_FRAME_HEADER_EN to prepend a frame-count header word to each drained frame.
module adc_frame_capture #(
  parameter int DATA_W  = 10,
  parameter int ADDR_W  = 8,
  parameter int DELAY_W = 16
) (
  input  logic               adc_clk,
  input  logic               rst,
  input  logic               i_main_sync,
  input  logic [DATA_W-1:0]  i_adc_data,
  input  logic [DELAY_W-1:0] i_delay,
  input  logic [ADDR_W:0]    i_length,
  output logic [DATA_W-1:0]  o_data,
  output logic               o_valid,
  output logic               o_last,
  input  logic               i_ready,
  output logic               o_busy,
  output logic               o_frame_done,
  output logic               o_overrun
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] FULL = {1'b1, {ADDR_W{1'b0}}};
`ifdef ADC_FRAME_HEADER_EN
  localparam logic [ADDR_W:0] HDR = {{ADDR_W{1'b0}}, 1'b1};
`else
  localparam logic [ADDR_W:0] HDR = '0;
`endif
  typedef enum logic [1:0] {IDLE, DELAY, CAPTURE, DRAIN} state_t;
  state_t state;
  logic [DATA_W-1:0]  mem [DEPTH];
  logic [DELAY_W-1:0] dly;
  logic [ADDR_W:0]    len, len_res, wr_ptr, rd_ptr, n_words;
  logic [ADDR_W-1:0]  rd_addr;
  logic [DATA_W-1:0]  rd_word;
  logic               load;
  assign len_res = (i_length == '0 || i_length > FULL) ? FULL : i_length;
  assign n_words = len + HDR;
  assign rd_addr = ADDR_W'(rd_ptr - HDR);
  assign load    = state == DRAIN && (!o_valid || i_ready) && rd_ptr != n_words;
  assign o_busy  = state != IDLE;
`ifdef ADC_FRAME_HEADER_EN
  logic [DATA_W-1:0] frame_cnt;
  always_ff @(posedge adc_clk or posedge rst)
    if (rst) frame_cnt <= '0;
    else if (o_frame_done) frame_cnt <= frame_cnt + 1'b1;
  assign rd_word = rd_ptr == '0 ? frame_cnt : mem[rd_addr];
`else
  assign rd_word = mem[rd_addr];
`endif
  always_ff @(posedge adc_clk)
    if (state == CAPTURE) mem[wr_ptr[ADDR_W-1:0]] <= i_adc_data;
  // Output register doubles as the prefetch stage: refilled whenever empty or being consumed.
  always_ff @(posedge adc_clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      dly          <= '0;
      len          <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      o_data       <= '0;
      o_valid      <= 1'b0;
      o_last       <= 1'b0;
      o_frame_done <= 1'b0;
      o_overrun    <= 1'b0;
    end else begin
      o_frame_done <= 1'b0;
      o_overrun    <= i_main_sync && state != IDLE;
      case (state)
        IDLE: if (i_main_sync) begin
          dly    <= i_delay;
          len    <= len_res;
          wr_ptr <= '0;
          rd_ptr <= '0;
          state  <= i_delay == '0 ? CAPTURE : DELAY;
        end
        DELAY: begin
          dly <= dly - 1'b1;
          if (dly == DELAY_W'(1)) state <= CAPTURE;
        end
        CAPTURE: begin
          wr_ptr <= wr_ptr + 1'b1;
          if (wr_ptr == len - 1'b1) state <= DRAIN;
        end
        DRAIN: if (o_frame_done) state <= IDLE;
        else if (load) begin
          o_valid <= 1'b1;
          o_data  <= rd_word;
          o_last  <= rd_ptr == n_words - 1'b1;
          rd_ptr  <= rd_ptr + 1'b1;
        end else if (o_valid && i_ready) begin
          o_valid      <= 1'b0;
          o_last       <= 1'b0;
          o_frame_done <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_adc_frame_capture.sv
// tb_adc_frame_capture: randomized frames checked cycle by cycle against a sample-history reference model.
module tb_adc_frame_capture;
  localparam int DATA_W = 10, ADDR_W = 8, DELAY_W = 16, DEPTH = 1 << ADDR_W;
`ifdef ADC_FRAME_HEADER_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif
  logic adc_clk = 1'b0, rst = 1'b1, i_main_sync = 1'b0, i_ready = 1'b0;
  logic [DATA_W-1:0] i_adc_data = '0;
  logic [DELAY_W-1:0] i_delay = '0;
  logic [ADDR_W:0] i_length = '0;
  logic [DATA_W-1:0] o_data;
  logic o_valid, o_last, o_busy, o_frame_done, o_overrun;
  adc_frame_capture #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DELAY_W(DELAY_W)) dut (
    .adc_clk(adc_clk), .rst(rst), .i_main_sync(i_main_sync), .i_adc_data(i_adc_data),
    .i_delay(i_delay), .i_length(i_length), .o_data(o_data), .o_valid(o_valid),
    .o_last(o_last), .i_ready(i_ready), .o_busy(o_busy), .o_frame_done(o_frame_done),
    .o_overrun(o_overrun)
  );
  always #5 adc_clk = ~adc_clk;
  int checks, failures, cyc;
  logic [DATA_W-1:0] hist [int];
  bit m_busy, exp_ovr, exp_done, in_frame, got_valid;
  int fs, fd, fl, nw, k, drain_start, frames_done;
  logic [DATA_W-1:0] hdr_val;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, got, want);
    end
  endtask
  function automatic logic [DATA_W-1:0] exp_word(input int idx);
    return (HDR == 1 && idx == 0) ? hdr_val : hist[fs + fd + 1 + idx - HDR];
  endfunction
  task automatic check_cycle();
    bit win;
    check("busy", o_busy, m_busy);
    check("overrun", o_overrun, exp_ovr);
    check("frame_done", o_frame_done, exp_done);
    win = in_frame && cyc >= drain_start && k < nw;
    if (win && o_valid) got_valid = 1;
    if (win && o_valid) begin
      check("data", o_data, exp_word(k));
      check("last", o_last, k == nw - 1);
    end else begin
      check("valid_idle", o_valid, 0);
      check("last_idle", o_last, 0);
    end
    if (win && !o_valid && got_valid) check("no_bubble", o_valid, 1);
    if (in_frame && cyc == drain_start + 2) check("valid_latency", got_valid, 1);
  endtask
  task automatic advance();
    bit busy_n, done_n;
    busy_n = m_busy;
    done_n = 0;
    if (in_frame && o_valid && i_ready && k < nw) begin
      k++;
      done_n = k == nw;
    end
    if (exp_done) begin
      busy_n = 0;
      in_frame = 0;
      frames_done++;
    end
    if (i_main_sync && !m_busy) begin
      fs = cyc;
      fd = int'(i_delay);
      fl = (i_length == 0 || i_length > DEPTH) ? DEPTH : int'(i_length);
      nw = fl + HDR;
      k = 0;
      got_valid = 0;
      in_frame = 1;
      busy_n = 1;
      drain_start = fs + fd + fl + 1;
      hdr_val = DATA_W'(frames_done);
    end
    exp_ovr = i_main_sync && m_busy;
    m_busy = busy_n;
    exp_done = done_n;
  endtask
  task automatic step(input bit sync, input int rdy_pct);
    i_main_sync = sync;
    i_ready = $urandom_range(99) < rdy_pct;
    i_adc_data = DATA_W'($urandom);
    if (!sync) begin
      i_delay = DELAY_W'($urandom);
      i_length = (ADDR_W + 1)'($urandom);
    end
    hist[cyc] = i_adc_data;
    @(negedge adc_clk);
    check_cycle();
    advance();
    @(posedge adc_clk);
    #1;
    cyc++;
  endtask
  task automatic run_frame(input int d, input int l, input int rdy_pct, input bit ovr, input bit b2b);
    bit s;
    i_delay = DELAY_W'(d);
    i_length = l[ADDR_W:0];
    step(1, rdy_pct);
    for (int n = 0; n < 2000 && m_busy; n++) begin
      s = (ovr && (cyc == fs + fd + 3 || cyc == drain_start + 3)) || (b2b && exp_done);
      step(s, rdy_pct);
    end
    check("frame_end", m_busy, 0);
  endtask
  task automatic rst_checks();
    check("rst_valid", o_valid, 0);
    check("rst_last", o_last, 0);
    check("rst_data", o_data, 0);
    check("rst_busy", o_busy, 0);
    check("rst_done", o_frame_done, 0);
    check("rst_overrun", o_overrun, 0);
  endtask
  task automatic reset_now();
    i_main_sync = 0;
    #2 rst = 1;
    #1 rst_checks();
    m_busy = 0;
    exp_ovr = 0;
    exp_done = 0;
    in_frame = 0;
    frames_done = 0;
    @(posedge adc_clk);
    #1 rst = 0;
    cyc++;
  endtask
  initial begin
    repeat (2) @(posedge adc_clk);
    #1 rst_checks();
    rst = 0;
    repeat (3) step(0, 100);
    i_delay = 2;
    i_length = 8;
    step(1, 100);
    for (int n = 0; n < 50 && !(m_busy && k == 3); n++) step(0, 100);
    check("reached_word3", k, 3);
    reset_now();
    repeat (2) step(0, 100);
    run_frame(1, 8, 100, 0, 0);
    run_frame(0, 4, 100, 0, 0);
    run_frame(3, 2, 100, 0, 0);
    run_frame(2, 8, 50, 0, 0);
    run_frame(4, 16, 70, 1, 0);
    run_frame(0, 5, 100, 0, 1);
    run_frame(1, 3, 100, 0, 0);
    run_frame(0, 0, 100, 0, 0);
    run_frame(2, 1, 100, 0, 0);
    run_frame(0, 300, 80, 0, 0);
    for (int i = 0; i < 12; i++)
      run_frame($urandom_range(6), $urandom_range(24, 1), $urandom_range(100, 30),
                1'($urandom_range(1)), 1'($urandom_range(1)));
    repeat (3) step(0, 100);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "simulation timeout");
  end
endmodule
